// File: rtl/dn_arb_pkg.sv
// Shared types and constants for the download/NVRAM port arbiter.
package dn_arb_pkg;

    // ioctl_index value of a ROM download.
    localparam logic [7:0] ROM_INDEX = 8'd0;

    // Width of the shared settle/read-latency counter (RD_LAT up to 7).
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StDl,
        StHsPause,
        StHsSettle,
        StHsReady,
        StHsRead
    } dn_arb_state_t;

endpackage

// File: rtl/dn_port_arbiter.sv
// Arbitrates the core's single download/NVRAM port between the HPS ioctl
// downloader and the hiscore engine. Downloads always win; hiscore accesses
// are only issued once the CPU is paused and a settle delay has elapsed.
module dn_port_arbiter
    import dn_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned NV_INDEX = 4,
    parameter int unsigned PAUSEPAD = 2,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [15:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              hs_req,
    input  logic              hs_we,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [7:0]        hs_wdata,
    output logic              hs_ack,
    output logic              hs_rvalid,
    output logic [7:0]        hs_rdata,
    output logic              hs_abort,
    output logic              pause_req,
    input  logic              paused,
    output logic [15:0]       dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              dn_nvram_wr,
    output logic              dn_nvram,
    input  logic [7:0]        dn_din,
    output logic              busy
);

    // Terminal counts; PAUSEPAD-1 is never used when PAUSEPAD is 0.
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(PAUSEPAD - 1);
    localparam logic [CNT_W-1:0] RdLast     = CNT_W'(RD_LAT - 1);

    dn_arb_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rdata_q, rdata_d;

    logic dl_rom;
    logic dl_nv;
    logic hs_own;
    logic preempt;

    assign dl_rom  = (ioctl_index == ROM_INDEX);
    assign dl_nv   = (ioctl_index == 8'(NV_INDEX));
    assign hs_own  = state_q inside {StHsPause, StHsSettle, StHsReady, StHsRead};
    assign preempt = hs_own & ioctl_download;

    // State, counter, held read address and captured read data.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic and the port output mux, keyed on the current state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        hs_ack      = 1'b0;
        hs_rvalid   = 1'b0;
        hs_abort    = 1'b0;
        pause_req   = 1'b0;
        dn_addr     = '0;
        dn_data     = '0;
        dn_wr       = 1'b0;
        dn_nvram_wr = 1'b0;
        dn_nvram    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ioctl_download) begin
                    state_d = StDl;
                end else if (hs_req) begin
                    state_d = StHsPause;
                end
            end
            StDl: begin
                if (!ioctl_download) begin
                    state_d = StIdle;
                end
            end
            StHsPause: begin
                pause_req = 1'b1;
                if (!hs_req) begin
                    state_d = StIdle;
                end else if (paused) begin
                    if (PAUSEPAD == 0) begin
                        state_d = StHsReady;
                    end else begin
                        state_d = StHsSettle;
                        cnt_d   = '0;
                    end
                end
            end
            StHsSettle: begin
                pause_req = 1'b1;
                if (!hs_req) begin
                    state_d = StIdle;
                end else if (!paused) begin
                    state_d = StHsPause;
                end else if (cnt_q == SettleLast) begin
                    state_d = StHsReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHsReady: begin
                pause_req = 1'b1;
                dn_nvram  = 1'b1;
                dn_addr   = 16'(hs_addr);
                if (!hs_req) begin
                    state_d = StIdle;
                end else begin
                    hs_ack = 1'b1;
                    if (hs_we) begin
                        dn_nvram_wr = 1'b1;
                        dn_data     = hs_wdata;
                    end else begin
                        addr_d  = hs_addr;
                        cnt_d   = '0;
                        state_d = StHsRead;
                    end
                end
            end
            StHsRead: begin
                pause_req = 1'b1;
                dn_nvram  = 1'b1;
                dn_addr   = 16'(addr_q);
                if (cnt_q == RdLast) begin
                    hs_rvalid = 1'b1;
                    rdata_d   = dn_din;
                    state_d   = StHsReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A download revokes hiscore ownership on the spot; any read in flight is dropped.
        if (preempt) begin
            hs_ack    = 1'b0;
            hs_rvalid = 1'b0;
            hs_abort  = 1'b1;
            pause_req = 1'b0;
            state_d   = StDl;
            cnt_d     = cnt_q;
            addr_d    = addr_q;
            rdata_d   = rdata_q;
        end

        // Download passthrough, also during the preempting cycle so no strobe is lost.
        if (state_q == StDl || preempt) begin
            dn_addr     = ioctl_addr;
            dn_data     = ioctl_dout;
            dn_wr       = ioctl_wr & dl_rom;
            dn_nvram_wr = ioctl_wr & dl_nv;
            dn_nvram    = dl_nv;
        end

        // Bypass so read data is already valid in the hs_rvalid cycle, then held.
        hs_rdata = hs_rvalid ? dn_din : rdata_q;
        busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_dn_port_arbiter.sv
// Self-checking bench for dn_port_arbiter: download passthrough table,
// hand-written hiscore sequences, and randomized traffic against a model.
module tb_dn_port_arbiter;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned NV_INDEX = 4;
    localparam int unsigned PAUSEPAD = 2;
    localparam int unsigned RD_LAT   = 2;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [15:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              hs_req;
    logic              hs_we;
    logic [ADDR_W-1:0] hs_addr;
    logic [7:0]        hs_wdata;
    logic              hs_ack;
    logic              hs_rvalid;
    logic [7:0]        hs_rdata;
    logic              hs_abort;
    logic              pause_req;
    logic              paused;
    logic [15:0]       dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wr;
    logic              dn_nvram_wr;
    logic              dn_nvram;
    logic [7:0]        dn_din;
    logic              busy;

    dn_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .NV_INDEX(NV_INDEX),
        .PAUSEPAD(PAUSEPAD),
        .RD_LAT  (RD_LAT)
    ) u_dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .hs_req        (hs_req),
        .hs_we         (hs_we),
        .hs_addr       (hs_addr),
        .hs_wdata      (hs_wdata),
        .hs_ack        (hs_ack),
        .hs_rvalid     (hs_rvalid),
        .hs_rdata      (hs_rdata),
        .hs_abort      (hs_abort),
        .pause_req     (pause_req),
        .paused        (paused),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_wr         (dn_wr),
        .dn_nvram_wr   (dn_nvram_wr),
        .dn_nvram      (dn_nvram),
        .dn_din        (dn_din),
        .busy          (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  idx;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        e_wr;
        logic        e_nvwr;
        logic        e_nv;
    } dl_vec_t;

    dl_vec_t tbl[8];

    // Reference model: who owns the port, whether the pause/settle handshake
    // is done, and how many cycles remain on an outstanding read.
    int          m_own;      // 0 none, 1 download, 2 hiscore
    bit          m_granted;
    int          m_settle;   // -1 while waiting for paused
    int          m_rd_left;  // 0 when no read is outstanding
    logic [9:0]  m_rd_addr;
    logic [7:0]  m_rdata;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] dut_vec();
        return {hs_ack, hs_rvalid, hs_rdata, hs_abort, pause_req, dn_addr, dn_data,
                dn_wr, dn_nvram_wr, dn_nvram, busy};
    endfunction

    function automatic logic [39:0] model_out();
        logic        ack;
        logic        rv;
        logic [7:0]  rd;
        logic        ab;
        logic        pr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic        nw;
        logic        nv;
        logic        b;
        ack = 0; rv = 0; rd = m_rdata; ab = 0; pr = 0; a = '0; d = '0; w = 0; nw = 0; nv = 0;
        if (m_own == 1 || (m_own == 2 && ioctl_download)) begin
            a  = ioctl_addr;
            d  = ioctl_dout;
            w  = ioctl_wr && (ioctl_index == 8'd0);
            nw = ioctl_wr && (ioctl_index == 8'(NV_INDEX));
            nv = (ioctl_index == 8'(NV_INDEX));
            ab = (m_own == 2);
        end else if (m_own == 2) begin
            pr = 1;
            if (m_granted) begin
                nv = 1;
                if (m_rd_left > 0) begin
                    a = {6'd0, m_rd_addr};
                    if (m_rd_left == 1) begin
                        rv = 1;
                        rd = dn_din;
                    end
                end else begin
                    a = {6'd0, hs_addr};
                    if (hs_req) begin
                        ack = 1;
                        if (hs_we) begin
                            nw = 1;
                            d  = hs_wdata;
                        end
                    end
                end
            end
        end
        b = (m_own != 0);
        return {ack, rv, rd, ab, pr, a, d, w, nw, nv, b};
    endfunction

    task automatic model_step();
        if (m_own == 0) begin
            if (ioctl_download) m_own = 1;
            else if (hs_req) begin
                m_own = 2; m_granted = 0; m_settle = -1; m_rd_left = 0;
            end
        end else if (m_own == 1) begin
            if (!ioctl_download) m_own = 0;
        end else if (ioctl_download) begin
            m_own = 1;
        end else if (!m_granted) begin
            if (!hs_req) m_own = 0;
            else if (m_settle < 0) begin
                if (paused) begin
                    if (PAUSEPAD == 0) m_granted = 1;
                    else m_settle = PAUSEPAD;
                end
            end else if (!paused) begin
                m_settle = -1;
            end else begin
                m_settle--;
                if (m_settle == 0) m_granted = 1;
            end
        end else if (m_rd_left > 0) begin
            if (m_rd_left == 1) m_rdata = dn_din;
            m_rd_left--;
        end else if (!hs_req) begin
            m_own = 0;
        end else if (!hs_we) begin
            m_rd_left = RD_LAT;
            m_rd_addr = hs_addr;
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (n < 20 && !hs_ack) begin
            cyc();
            #2;
            n++;
        end
        if (!hs_ack) chk(name, 40'(0), 40'(1));
    endtask

    initial begin
        int n;
        bit dl_r;

        reset = 1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0;
        ioctl_dout = 0; hs_req = 0; hs_we = 0; hs_addr = 0; hs_wdata = 0; paused = 0; dn_din = 0;

        // Reset state
        cyc(); cyc();
        #2 chk("reset_outputs", dut_vec(), 40'(0));
        cyc();
        reset = 0;
        #2 chk("idle_outputs", dut_vec(), 40'(0));

        // Download passthrough table
        tbl[0] = '{8'd0, 1'b1, 16'h0000, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'd0, 1'b1, 16'h0001, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'd0, 1'b1, 16'h0002, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'd0, 1'b1, 16'h0003, 8'h44, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'd0, 1'b0, 16'h0004, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'd4, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{8'd4, 1'b0, 16'h0011, 8'h5A, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'd7, 1'b1, 16'hBEEF, 8'h99, 1'b0, 1'b0, 1'b0};
        cyc();
        ioctl_download = 1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            ioctl_index = tbl[i].idx; ioctl_wr = tbl[i].wr;
            ioctl_addr = tbl[i].addr; ioctl_dout = tbl[i].dout;
            #2;
            chk("dl_addr", 40'(dn_addr), 40'(tbl[i].addr));
            chk("dl_data", 40'(dn_data), 40'(tbl[i].dout));
            chk("dl_strobes", 40'({dn_wr, dn_nvram_wr, dn_nvram, busy}),
                40'({tbl[i].e_wr, tbl[i].e_nvwr, tbl[i].e_nv, 1'b1}));
        end
        cyc();
        ioctl_download = 0; ioctl_wr = 0; ioctl_index = 0;
        cyc();
        #2 chk("dl_release_busy", 40'(busy), 40'(0));

        // Hiscore write: pause handshake, settle delay, then writes
        hs_req = 1; hs_we = 1; hs_addr = 10'h3FF; hs_wdata = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #2 chk("pause_wait", 40'({pause_req, hs_ack}), 40'(2'b10));
        end
        cyc();
        paused = 1;
        // One edge samples paused, then PAUSEPAD settle edges before the ack cycle.
        n = 0;
        #2;
        while (n < 20 && !hs_ack) begin
            cyc();
            #2;
            n++;
        end
        chk("ack_delay", 40'(n), 40'(PAUSEPAD + 1));
        chk("hs_write", 40'({dn_addr, dn_data, dn_nvram_wr, dn_nvram}),
            40'({16'h03FF, 8'h3C, 1'b1, 1'b1}));
        cyc();
        hs_addr = 10'h155; hs_wdata = 8'hC3;
        #2 chk("hs_write_b2b", 40'({hs_ack, dn_addr, dn_data, dn_nvram_wr}),
               40'({1'b1, 16'h0155, 8'hC3, 1'b1}));

        // Hiscore read: address held, rvalid RD_LAT cycles after the ack
        cyc();
        hs_we = 0; hs_addr = 10'h012; dn_din = 8'h77;
        #2 chk("hs_read_ack", 40'({hs_ack, dn_nvram_wr, dn_addr}), 40'({1'b1, 1'b0, 16'h0012}));
        n = 0;
        cyc();
        hs_addr = 10'h2AA;
        #2;
        n = 1;
        while (n < 20 && !hs_rvalid) begin
            chk("no_ack_in_read", 40'(hs_ack), 40'(0));
            cyc();
            #2;
            n++;
        end
        chk("rvalid_delay", 40'(n), 40'(RD_LAT));
        chk("rvalid_data", 40'({hs_rdata, dn_addr, hs_ack}), 40'({8'h77, 16'h0012, 1'b0}));
        cyc();
        hs_req = 0; dn_din = 8'h00;
        #2 chk("rdata_hold", 40'({hs_rdata, pause_req, hs_ack}), 40'({8'h77, 1'b1, 1'b0}));
        cyc();
        #2 chk("release", 40'({pause_req, busy}), 40'(0));

        // Preemption during a read
        hs_req = 1; hs_we = 0; hs_addr = 10'h040; dn_din = 8'hEE;
        cyc();
        #2;
        wait_ack("preempt_ack_timeout");
        cyc();
        ioctl_download = 1; ioctl_index = 0; ioctl_wr = 0;
        #2 chk("abort_pulse", 40'({hs_abort, pause_req, hs_rvalid}), 40'(3'b100));
        cyc();
        hs_req = 0;
        #2 chk("after_abort", 40'({hs_abort, pause_req, hs_rvalid, busy}), 40'(4'b0001));
        for (int i = 0; i < 2; i++) begin
            cyc();
            #2 chk("no_rvalid_dl", 40'({hs_rvalid, hs_rdata}), 40'({1'b0, 8'h77}));
        end
        ioctl_download = 0;
        cyc(); cyc();

        // Async reset mid-read
        hs_req = 1; hs_addr = 10'h001;
        cyc();
        #2;
        wait_ack("reset_ack_timeout");
        cyc();
        #1 reset = 1;
        #1 chk("async_reset", dut_vec(), 40'(0));
        hs_req = 0; paused = 0;
        cyc();
        reset = 0;

        // Randomized traffic against the reference model
        m_own = 0; m_granted = 0; m_settle = -1; m_rd_left = 0; m_rd_addr = 0; m_rdata = 0;
        dl_r = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(0, 29) == 0) dl_r = ~dl_r;
            ioctl_download = dl_r;
            case ($urandom_range(0, 2))
                0: ioctl_index = 8'd0;
                1: ioctl_index = 8'(NV_INDEX);
                default: ioctl_index = 8'd7;
            endcase
            ioctl_wr   = 1'($urandom);
            ioctl_addr = 16'($urandom);
            ioctl_dout = 8'($urandom);
            if ($urandom_range(0, 11) == 0) hs_req = ~hs_req;
            hs_we    = 1'($urandom);
            hs_addr  = 10'($urandom);
            hs_wdata = 8'($urandom);
            paused   = ($urandom_range(0, 7) != 0);
            dn_din   = 8'($urandom);
            #2;
            chk("random", dut_vec(), model_out());
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
